univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised universal shift register, successor to the 1-bit SISO register.
//  DEPTH stages of WIDTH bits each, with forward/backward shift, rotate, parallel load and clear.
//  Adds an autonomous burst serializer: loads pIn, then shifts out DEPTH symbols, then pulses done.
//  Sits between parallel datapaths and serial links in the lab designs.
// PARAMETERS
//  WIDTH  1  bits per stage (serial symbol width)
//  DEPTH  4  number of stages; must be >= 2
// PORTS
//  clk    in   1            rising-edge clock; the only clock
//  nRst   in   1            reset, synchronous, active-low
//  en     in   1            clock enable; when low, all state holds, including the burst counter
//  mode   in   3            operation select; ignored while busy
//  start  in   1            starts a burst; sampled only in IDLE with en=1
//  sIn    in   WIDTH        serial input, forward direction (enters stage 0)
//  sInB   in   WIDTH        serial input, backward direction (enters stage DEPTH-1)
//  pIn    in   WIDTH*DEPTH  parallel load data; stage i = pIn[i*WIDTH +: WIDTH]
//  sOut   out  WIDTH        = stage[DEPTH-1]
//  sOutB  out  WIDTH        = stage[0]
//  pOut   out  WIDTH*DEPTH  all stages, packed in the same way as pIn
//  busy   out  1            high while a burst is in progress
//  done   out  1            one-cycle pulse after the last burst shift
// BEHAVIOUR
//  Reset (nRst=0 at a clk edge): all stages=0, FSM=IDLE, cnt=0, busy=0, done=0.
//   Reset overrides en, start and mode, and aborts any burst in progress.
//  Modes (IDLE, en=1, start=0), applied at the clock edge:
//   000 HOLD   no change
//   001 FWD    stage[0]<=sIn; stage[i]<=stage[i-1]
//   010 BWD    stage[DEPTH-1]<=sInB; stage[i]<=stage[i+1]
//   011 ROTF   like FWD, but stage[0]<=stage[DEPTH-1]
//   100 ROTB   like BWD, but stage[DEPTH-1]<=stage[0]
//   101 LOAD   stage[i]<=pIn slice i
//   110 CLR    all stages<=0
//   111        reserved; behaves as HOLD
//  Latency:
//   sOut/sOutB/pOut are registered outputs with no combinational input path.
//   A symbol on sIn reaches sOut after DEPTH FWD edges.
//  FSM states: IDLE, BURST.
//   IDLE->BURST: en&start. At that edge, stages<=pIn, cnt<=0, busy<=1. Start has priority over mode.
//   BURST: each en=1 edge performs FWD using sIn, and cnt<=cnt+1.
//    sOut presents pIn slice DEPTH-1 first, then slice DEPTH-2, and so on.
//   BURST->IDLE: on the edge where cnt==DEPTH-1 (the DEPTH-th shift), busy<=0 and done<=1 for exactly one cycle.
//   In BURST, mode and start are ignored; a start held high does not restart the burst.
//   A start in the cycle where done=1 is accepted (FSM is IDLE), so back-to-back bursts are allowed.
//   en=0 in BURST stalls the burst: cnt, stages and busy hold; done stays 0.
//  cnt width: $clog2(DEPTH), minimum 1; it never wraps within a burst.
//  done is 0 at all times other than the pulse described above.
// STRUCTURE
//  shift_reg_pkg:
//   mode localparams MODE_HOLD..MODE_CLR (3-bit), and the FSM state encoding IDLE=1'b0, BURST=1'b1.
//  Sub-module shift_stage:
//   one WIDTH-bit register with a 4:1 input mux (hold / from-prev / from-next / load) and a sync clear.
//   Instantiated DEPTH times in a generate loop.
//  The top level holds the FSM, the counter, the end-of-chain muxing (sIn/sInB vs. rotate) and the mode decode.
// TESTING (WIDTH=1, DEPTH=4 unless noted; 200 ns clock)
//  1 Reset: nRst=0 for 1 edge while mode=LOAD, pIn=4'hF -> pOut=0, sOut=0, busy=0, done=0.
//  2 FWD: sIn pattern 1,0,0,1,1 over 5 edges -> sOut=1 at the 4th edge, pOut=4'b0011 after the 5th edge.
//  3 ROTF/ROTB: LOAD 4'b0001, ROTF x4 -> 4'b0001; ROTB x1 -> 4'b1000.
//  4 Burst (WIDTH=8):
//    pIn=32'hDDCCBBAA, start for 1 cycle -> sOut sequence DD,CC,BB,AA; busy high 4 cycles; done pulses once.
//    Drop en for 2 cycles mid-burst -> sequence is unchanged, busy is stretched by 2 cycles.
//  5 Ignored inputs: mode=CLR and start=1 during BURST -> no effect. Start in the done cycle -> second burst begins.
//  6 Reset mid-burst after 2 shifts -> next edge: IDLE, pOut=0, no done pulse.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared mode codes, FSM encoding and stage mux selects for univ_shift_reg.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_FWD  = 3'b001;
  localparam logic [2:0] MODE_BWD  = 3'b010;
  localparam logic [2:0] MODE_ROTF = 3'b011;
  localparam logic [2:0] MODE_ROTB = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Per-stage input mux selection, shared by every stage in the chain.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_PREV = 2'd1,
    SEL_NEXT = 2'd2,
    SEL_LOAD = 2'd3
  } stage_sel_e;

endpackage

// File: rtl/shift_stage.sv
// One WIDTH-bit stage of the shift chain: 4:1 input mux plus synchronous clear.
module shift_stage
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             nRst,
  input  stage_sel_e       sel_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] next_i,
  input  logic [WIDTH-1:0] load_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Select the next stage value from hold / neighbour / parallel data.
  always_comb begin
    q_d = q_q;
    unique case (sel_i)
      SEL_HOLD: q_d = q_q;
      SEL_PREV: q_d = prev_i;
      SEL_NEXT: q_d = next_i;
      SEL_LOAD: q_d = load_i;
      default:  q_d = q_q;
    endcase
  end

  // Stage register; reset and clear both force zero.
  always_ff @(posedge clk) begin
    if (!nRst || clr_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: DEPTH stages of WIDTH bits with shift, rotate,
// load, clear and an autonomous burst serializer.
//
// Burst handshake: start is taken only when idle (busy=0) with en=1; busy is
// high for every cycle of the burst and done pulses for one cycle after the
// last shift. busy is the decoded FSM state (busy == (state == BURST)).
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic               start,
  input  logic [WIDTH-1:0]   sIn,
  input  logic [WIDTH-1:0]   sInB,
  input  logic [WIDTH*DEPTH-1:0] pIn,
  output logic [WIDTH-1:0]   sOut,
  output logic [WIDTH-1:0]   sOutB,
  output logic [WIDTH*DEPTH-1:0] pOut,
  output logic               busy,
  output logic               done
);

  localparam int CW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  stage_sel_e       sel;
  logic             clr;
  logic [WIDTH-1:0] fwd_in;
  logic [WIDTH-1:0] bwd_in;

  logic [WIDTH-1:0] stage_w [DEPTH];
  logic [WIDTH-1:0] prev_w  [DEPTH];
  logic [WIDTH-1:0] next_w  [DEPTH];

  // Mode decode, end-of-chain muxing and burst FSM next state.
  always_comb begin
    sel     = SEL_HOLD;
    clr     = 1'b0;
    fwd_in  = sIn;
    bwd_in  = sInB;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            // Start wins over mode: capture pIn and begin serializing.
            sel     = SEL_LOAD;
            state_d = BURST;
            cnt_d   = '0;
          end else begin
            case (mode)
              MODE_FWD:  sel = SEL_PREV;
              MODE_BWD:  sel = SEL_NEXT;
              MODE_ROTF: begin
                sel    = SEL_PREV;
                fwd_in = stage_w[DEPTH-1];
              end
              MODE_ROTB: begin
                sel    = SEL_NEXT;
                bwd_in = stage_w[0];
              end
              MODE_LOAD: sel = SEL_LOAD;
              MODE_CLR:  clr = 1'b1;
              default:   sel = SEL_HOLD;
            endcase
          end
        end
        BURST: begin
          // Mode and start are ignored; every enabled edge is a FWD shift.
          sel = SEL_PREV;
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, burst counter and done pulse registers.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign prev_w[i] = fwd_in;
    end else begin : g_mid_prev
      assign prev_w[i] = stage_w[i-1];
    end
    if (i == DEPTH - 1) begin : g_last
      assign next_w[i] = bwd_in;
    end else begin : g_mid_next
      assign next_w[i] = stage_w[i+1];
    end

    shift_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .nRst   (nRst),
      .sel_i  (sel),
      .clr_i  (clr),
      .prev_i (prev_w[i]),
      .next_i (next_w[i]),
      .load_i (pIn[i*WIDTH +: WIDTH]),
      .q_o    (stage_w[i])
    );

    assign pOut[i*WIDTH +: WIDTH] = stage_w[i];
  end

  assign sOut  = stage_w[DEPTH-1];
  assign sOutB = stage_w[0];
  assign busy  = (state_q == BURST);
  assign done  = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Testbench for univ_shift_reg: a WIDTH=1 instance for the shift/rotate modes
// and a WIDTH=8 instance for the burst serializer, both DEPTH=4.
`timescale 1ns/1ps
module tb_univ_shift_reg;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_FWD  = 3'b001;
  localparam logic [2:0] M_BWD  = 3'b010;
  localparam logic [2:0] M_ROTF = 3'b011;
  localparam logic [2:0] M_ROTB = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #100 clk = ~clk;

  logic        nRst;
  logic        en;
  // WIDTH=1 instance
  logic [2:0]  mode1;
  logic        start1;
  logic        sIn1, sInB1;
  logic [3:0]  pIn1;
  logic        sOut1, sOutB1;
  logic [3:0]  pOut1;
  logic        busy1, done1;
  // WIDTH=8 instance
  logic [2:0]  mode8;
  logic        start8;
  logic [7:0]  sIn8, sInB8;
  logic [31:0] pIn8;
  logic [7:0]  sOut8, sOutB8;
  logic [31:0] pOut8;
  logic        busy8, done8;

  univ_shift_reg #(.WIDTH(1), .DEPTH(4)) u_dut1 (
    .clk(clk), .nRst(nRst), .en(en), .mode(mode1), .start(start1),
    .sIn(sIn1), .sInB(sInB1), .pIn(pIn1),
    .sOut(sOut1), .sOutB(sOutB1), .pOut(pOut1), .busy(busy1), .done(done1)
  );

  univ_shift_reg #(.WIDTH(8), .DEPTH(4)) u_dut8 (
    .clk(clk), .nRst(nRst), .en(en), .mode(mode8), .start(start8),
    .sIn(sIn8), .sInB(sInB8), .pIn(pIn8),
    .sOut(sOut8), .sOutB(sOutB8), .pOut(pOut8), .busy(busy8), .done(done8)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  exp_q[$];   // expected burst symbols on sOut8
  logic [3:0]  exp1_q[$];  // expected pOut1 after each edge
  logic [31:0] m1, m8;     // stage models, 8-bit lanes, lane i = stage i
  logic        b_busy, b_done;
  int          b_cnt;
  int          busy_cnt, done_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s, input logic [2:0] md,
                                       input logic [7:0] si, input logic [7:0] sib,
                                       input logic [31:0] pin);
    case (md)
      M_FWD:   return {s[23:0], si};
      M_BWD:   return {sib, s[31:8]};
      M_ROTF:  return {s[23:0], s[31:24]};
      M_ROTB:  return {s[7:0], s[31:8]};
      M_LOAD:  return pin;
      M_CLR:   return 32'h0;
      default: return s;
    endcase
  endfunction

  function automatic logic [31:0] expand1(input logic [3:0] p);
    return {7'b0, p[3], 7'b0, p[2], 7'b0, p[1], 7'b0, p[0]};
  endfunction

  function automatic logic [3:0] pack1(input logic [31:0] s);
    return {s[24], s[16], s[8], s[0]};
  endfunction

  // ---------------- driver: one clock edge with prediction and checking ----------------
  task automatic tick();
    logic samp;
    // WIDTH=1 prediction (never bursts)
    if (!nRst)   m1 = 32'h0;
    else if (en) m1 = step(m1, mode1, {7'b0, sIn1}, {7'b0, sInB1}, expand1(pIn1));
    exp1_q.push_back(pack1(m1));
    // WIDTH=8 prediction including burst FSM
    b_done = 1'b0;
    samp   = 1'b0;
    if (!nRst) begin
      m8 = 32'h0; b_busy = 1'b0; b_cnt = 0;
      exp_q.delete();
    end else if (en) begin
      if (!b_busy) begin
        if (start8) begin
          m8 = pIn8; b_busy = 1'b1; b_cnt = 0; samp = 1'b1;
          for (int k = 3; k >= 0; k--) exp_q.push_back(pIn8[k*8 +: 8]);
        end else begin
          m8 = step(m8, mode8, sIn8, sInB8, pIn8);
        end
      end else begin
        m8 = {m8[23:0], sIn8};
        if (b_cnt == 3) begin
          b_busy = 1'b0; b_done = 1'b1;
        end else begin
          b_cnt++; samp = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("pout1", pOut1, exp1_q.pop_front());
    check("sout1", sOut1, m1[24]);
    check("soutb1", sOutB1, m1[0]);
    check("pout8", pOut8, m8);
    check("busy8", busy8, b_busy);
    check("done8", done8, b_done);
    if (samp) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check("sout8", sOut8, exp_q.pop_front());
    end
    if (busy8) busy_cnt++;
    if (done8) done_cnt++;
  endtask

  task automatic idle_inputs();
    start8 = 1'b0; mode8 = M_HOLD; mode1 = M_HOLD; en = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    nRst = 1'b0; en = 1'b1; start1 = 1'b0; start8 = 1'b0;
    mode1 = M_LOAD; pIn1 = 4'hF; sIn1 = 1'b0; sInB1 = 1'b0;
    mode8 = M_LOAD; pIn8 = 32'hFFFF_FFFF; sIn8 = 8'h0; sInB8 = 8'h0;
    m1 = 32'h0; m8 = 32'h0; b_busy = 1'b0; b_done = 1'b0; b_cnt = 0;
    busy_cnt = 0; done_cnt = 0;

    // Reset while LOAD is requested
    tick();
    check("rst_pout1", pOut1, 32'h0);
    check("rst_sout1", sOut1, 32'h0);
    check("rst_busy1", busy1, 32'h0);
    check("rst_done1", done1, 32'h0);
    check("rst_pout8", pOut8, 32'h0);
    nRst = 1'b1;
    idle_inputs();

    // FWD: 1,0,0,1,1
    mode1 = M_FWD;
    for (int i = 0; i < 5; i++) begin
      sIn1 = (i == 0 || i >= 3);
      tick();
      if (i == 3) check("fwd_sout_4th", sOut1, 32'h1);
    end
    check("fwd_pout", pOut1, 32'h3);

    // ROTF x4 returns to start, ROTB x1 moves bit 0 to stage 3
    mode1 = M_LOAD; pIn1 = 4'b0001; tick();
    mode1 = M_ROTF;
    for (int i = 0; i < 4; i++) tick();
    check("rotf4", pOut1, 32'h1);
    mode1 = M_ROTB; tick();
    check("rotb1", pOut1, 32'h8);
    mode1 = M_BWD; sInB1 = 1'b1; tick();
    check("bwd", pOut1, 32'hC);

    // Random modes on both instances (no bursts)
    for (int i = 0; i < 24; i++) begin
      mode1 = 3'($urandom_range(0, 7)); mode8 = 3'($urandom_range(0, 7));
      sIn1 = 1'($urandom_range(0, 1)); sInB1 = 1'($urandom_range(0, 1));
      pIn1 = 4'($urandom_range(0, 15));
      sIn8 = 8'($urandom_range(0, 255)); sInB8 = 8'($urandom_range(0, 255));
      pIn8 = $urandom();
      en = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle_inputs();

    // Burst DDCCBBAA
    busy_cnt = 0; done_cnt = 0;
    pIn8 = 32'hDDCC_BBAA; start8 = 1'b1; tick();
    check("burst_first", sOut8, 32'hDD);
    start8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sIn8 = 8'($urandom_range(0, 255)); tick();
    end
    check("burst_busy_cycles", busy_cnt, 32'd4);
    check("burst_done_count", done_cnt, 32'd1);

    // Burst with en dropped for 2 cycles mid-burst
    busy_cnt = 0; done_cnt = 0;
    start8 = 1'b1; tick();
    start8 = 1'b0; tick();
    en = 1'b0; tick(); tick();
    check("stall_done_low", done8, 32'h0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("stall_busy_cycles", busy_cnt, 32'd6);
    check("stall_done_count", done_cnt, 32'd1);

    // Mode=CLR and start held during burst; start in the done cycle restarts
    busy_cnt = 0; done_cnt = 0;
    pIn8 = 32'h1234_5678; start8 = 1'b1; mode8 = M_CLR; tick();
    pIn8 = 32'h99AA_BBCC;
    for (int i = 0; i < 4; i++) tick();
    check("done_cycle", done8, 32'h1);
    tick();
    check("restart_busy", busy8, 32'h1);
    check("restart_first", sOut8, 32'h99);
    start8 = 1'b0; mode8 = M_HOLD;
    for (int i = 0; i < 5; i++) tick();
    check("b2b_done_count", done_cnt, 32'd2);

    // Reset mid-burst after 2 shifts
    done_cnt = 0;
    pIn8 = 32'h5566_7788; start8 = 1'b1; tick();
    start8 = 1'b0; tick(); tick();
    nRst = 1'b0; tick();
    check("rst_mid_busy", busy8, 32'h0);
    check("rst_mid_pout", pOut8, 32'h0);
    nRst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_mid_no_done", done_cnt, 32'd0);

    // Random bursts with random enable
    for (int b = 0; b < 4; b++) begin
      pIn8 = $urandom(); start8 = 1'b1; en = 1'b1; tick();
      start8 = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        en = ($urandom_range(0, 2) != 0);
        sIn8 = 8'($urandom_range(0, 255));
        mode8 = 3'($urandom_range(0, 7));
        tick();
      end
      start8 = 1'b0; mode8 = M_HOLD; en = 1'b1;
      while (b_busy) tick();
      tick();
    end
    check("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
